// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive peripheral: register map, bit fields and FSM encoding.
package uart_rx_pkg;

    localparam logic [7:0] REG_RX_DATA = 8'd0;
    localparam logic [7:0] REG_STATUS  = 8'd1;
    localparam logic [7:0] REG_CTRL    = 8'd2;

    localparam int unsigned STAT_NOT_EMPTY = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_OVERRUN   = 2;
    localparam int unsigned STAT_FRAMING   = 3;
    localparam int unsigned STAT_COUNT_LSB = 4;

    localparam int unsigned CTRL_IRQ_EN  = 0;
    localparam int unsigned CTRL_CLR_ERR = 1;
    localparam int unsigned CTRL_FLUSH   = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

    // STATUS only has room for a 3-bit count.
    function automatic logic [2:0] sat_count(input logic [4:0] count);
        return (count > 5'd7) ? 3'd7 : count[2:0];
    endfunction

endpackage

// File: rtl/uart_rx_peripheral_if.sv
// Shared 8-bit processor bus as seen by the UART receive peripheral, including the tristate data
// lines and the interrupt handshake.
interface uart_rx_peripheral_if;

    logic [7:0] bus_addr;
    logic       bus_we;
    logic [7:0] cpu_wdata;
    logic       cpu_drive;
    logic [7:0] rd_data;
    logic       rd_oe;
    logic       irq_raise;
    logic       irq_ack;
    wire  [7:0] bus_data;

    // Each side only drives the shared lines while it owns them.
    assign bus_data = cpu_drive ? cpu_wdata : 8'hzz;
    assign bus_data = rd_oe     ? rd_data   : 8'hzz;

    modport master (
        output bus_addr, bus_we, cpu_wdata, cpu_drive, irq_ack,
        input  bus_data, rd_oe, irq_raise
    );

    modport slave (
        input  bus_addr, bus_we, bus_data, irq_ack,
        output rd_data, rd_oe, irq_raise
    );

endinterface

// File: rtl/rx_fifo.sv
// Small synchronous FIFO for received bytes; flush takes priority over push and pop.
module rx_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/uart_rx_peripheral.sv
// 8N1 UART receiver with a byte FIFO, memory-mapped RX_DATA/STATUS/CTRL registers on the shared
// 8-bit bus and a new-byte interrupt.
module uart_rx_peripheral
    import uart_rx_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR    = 8'hE0,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_uart_rx,
    uart_rx_peripheral_if.slave  bus
);

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] ADDR_RX     = BASE_ADDR + REG_RX_DATA;
    localparam logic [7:0] ADDR_STATUS = BASE_ADDR + REG_STATUS;
    localparam logic [7:0] ADDR_CTRL   = BASE_ADDR + REG_CTRL;

    logic             r_rx_meta;
    logic             r_rx_sync;
    logic [1:0]       r_sync_fill;
    logic             r_armed;
    rx_state_e        r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_irq_en;
    logic             r_overrun;
    logic             r_framing;
    logic             r_irq_raise;
    logic [7:0]       r_rd_data;
    logic             r_rd_oe;

    logic              w_tick;
    logic              w_stop_sample;
    logic              w_push;
    logic              w_overrun_set;
    logic              w_framing_set;
    logic              w_ctrl_wr;
    logic              w_clr_err;
    logic              w_flush;
    logic              w_rd_hit;
    logic              w_pop;
    logic [7:0]        w_head;
    logic [FCNT_W-1:0] w_count;
    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_status;
    logic [7:0]        w_rd_mux;
    logic              w_unused_wdata;

    // The fill shift marks when the synchroniser holds a real pin sample rather than its reset value,
    // so a line held low through reset release is never mistaken for a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_sync_fill <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_rx_meta   <= i_uart_rx;
            r_rx_sync   <= r_rx_meta;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            if (r_rx_sync && r_sync_fill[1]) r_armed <= 1'b1;
        end
    end

    assign w_tick = (r_baud_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (r_armed && !r_rx_sync) begin
                        r_baud_cnt <= CNT_HALF;
                        r_state    <= StStart;
                    end
                end
                StStart: begin
                    if (!w_tick) begin
                        r_baud_cnt <= r_baud_cnt - CNT_W'(1);
                    end else if (r_rx_sync) begin
                        r_state <= StIdle;
                    end else begin
                        r_baud_cnt <= CNT_FULL;
                        r_bit_idx  <= '0;
                        r_state    <= StData;
                    end
                end
                StData: begin
                    if (!w_tick) begin
                        r_baud_cnt <= r_baud_cnt - CNT_W'(1);
                    end else begin
                        r_shift    <= {r_rx_sync, r_shift[7:1]};
                        r_baud_cnt <= CNT_FULL;
                        if (r_bit_idx == 3'd7) r_state <= StStop;
                        else                   r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                StStop: begin
                    if (!w_tick) r_baud_cnt <= r_baud_cnt - CNT_W'(1);
                    else         r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_stop_sample = (r_state == StStop) && w_tick;
    assign w_push        = w_stop_sample && r_rx_sync && !w_full;
    assign w_overrun_set = w_stop_sample && r_rx_sync && w_full;
    assign w_framing_set = w_stop_sample && !r_rx_sync;

    assign w_ctrl_wr      = bus.bus_we && (bus.bus_addr == ADDR_CTRL);
    assign w_clr_err      = w_ctrl_wr && bus.bus_data[CTRL_CLR_ERR];
    assign w_flush        = w_ctrl_wr && bus.bus_data[CTRL_FLUSH];
    assign w_unused_wdata = ^bus.bus_data[7:3];

    assign w_rd_hit = !bus.bus_we && ((bus.bus_addr == ADDR_RX) ||
                                      (bus.bus_addr == ADDR_STATUS) ||
                                      (bus.bus_addr == ADDR_CTRL));
    assign w_pop    = !bus.bus_we && (bus.bus_addr == ADDR_RX) && !w_empty;

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_status                             = '0;
        w_status[STAT_NOT_EMPTY]             = !w_empty;
        w_status[STAT_FULL]                  = w_full;
        w_status[STAT_OVERRUN]               = r_overrun;
        w_status[STAT_FRAMING]               = r_framing;
        w_status[STAT_COUNT_LSB +: 3]        = sat_count(5'(w_count));
    end

    always_comb begin
        w_rd_mux = 8'h00;
        if (bus.bus_addr == ADDR_RX)          w_rd_mux = w_empty ? 8'h00 : w_head;
        else if (bus.bus_addr == ADDR_STATUS) w_rd_mux = w_status;
        else if (bus.bus_addr == ADDR_CTRL)   w_rd_mux = {7'b0, r_irq_en};
    end

    // A new error in the same cycle as clear_errors wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_en    <= 1'b0;
            r_overrun   <= 1'b0;
            r_framing   <= 1'b0;
            r_irq_raise <= 1'b0;
            r_rd_data   <= 8'h00;
            r_rd_oe     <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= bus.bus_data[CTRL_IRQ_EN];

            if (w_overrun_set)  r_overrun <= 1'b1;
            else if (w_clr_err) r_overrun <= 1'b0;

            if (w_framing_set)  r_framing <= 1'b1;
            else if (w_clr_err) r_framing <= 1'b0;

            if (w_push && r_irq_en) r_irq_raise <= 1'b1;
            else if (bus.irq_ack)   r_irq_raise <= 1'b0;

            r_rd_oe <= w_rd_hit;
            if (w_rd_hit) r_rd_data <= w_rd_mux;
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_oe     = r_rd_oe;
    assign bus.irq_raise = r_irq_raise;

endmodule
